control_cabina: RTL and testbench
=================================

Name: control_cabina

Overview:
- Consumer end of the request queue: takes the next queued floor request (`memoria` word) and drives the cabin to that floor.
- Sequence per request: move floor by floor, open the doors for a fixed time, then pulse `atendido` so the queue side pops the entry.
- Sits between the request-memory block and the motor/door drivers.
- Owns the authoritative current-floor register `piso`, which is fed back to the request-memory block.

Parameters:
- T_VIAJE, 8, clock cycles to travel one floor; legal range 1..65535.
- T_PUERTA, 4, clock cycles the doors stay open; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- solicitud  input  4  next request from memory; bit i = floor i (0..3).
- solicitud_valida  input  1  `solicitud` holds a pending request.
- listo  output  1  cabin idle and able to accept (combinational, `estado`==REPOSO).
- atendido  output  1  one-cycle pulse: request served, memory may pop.
- piso  output  2  current floor, registered.
- motor_sube  output  1  drive cabin up.
- motor_baja  output  1  drive cabin down.
- puerta_abierta  output  1  doors open.

Behaviour:
- Reset (async, rst_n=0):
  - estado=REPOSO, piso=0, destino=0, timer=0.
  - motor_sube=motor_baja=puerta_abierta=atendido=0; listo=1.
- Encoding:
  - States REPOSO, SUBIENDO, BAJANDO, PUERTA.
  - Single 16-bit down-counter `timer`.
- All outputs except `listo` are registered.
- Accept rule: in REPOSO, an edge with solicitud_valida=1 and solicitud!=0 accepts the request.
  - destino = index of the lowest set bit of `solicitud`; multi-bit words serve only the lowest floor.
  - solicitud=0 with valid=1 is ignored: no accept, no pulse.
  - Inputs are ignored in all states other than REPOSO.
- REPOSO transitions on accept:
  - destino > piso -> SUBIENDO, timer=T_VIAJE-1, motor_sube=1.
  - destino < piso -> BAJANDO, timer=T_VIAJE-1, motor_baja=1.
  - destino == piso -> PUERTA, timer=T_PUERTA-1, puerta_abierta=1.
- SUBIENDO / BAJANDO:
  - timer decrements each cycle.
  - On the edge where timer==0, piso increments (SUBIENDO) or decrements (BAJANDO).
  - If the new piso == destino: motor off, -> PUERTA, timer=T_PUERTA-1, puerta_abierta=1.
  - Otherwise timer=T_VIAJE-1 and motion continues.
  - piso never wraps: SUBIENDO at piso=3 or BAJANDO at piso=0 is unreachable by construction.
  - If that case occurs anyway, force -> PUERTA without changing piso.
- PUERTA:
  - timer decrements each cycle.
  - On the edge where timer==0: puerta_abierta=0, -> REPOSO, atendido=1 for exactly that next cycle.
- Back-to-back requests: in the atendido cycle listo=1, so a new request presented then is accepted on that same edge.
- Latency: accept edge k; floor reached at edge k+d*T_VIAJE (d = floor distance).
  - Doors close at k+d*T_VIAJE+T_PUERTA.
  - atendido is high during the following cycle.
- Motion interlock: motor_sube and motor_baja are never both 1; puerta_abierta is never 1 while either motor is 1.
- Reset mid-operation: immediate return to reset values. Any in-flight request is not acknowledged; memory retains it.

Optional Feature:
- Macro: PARADA_EMERGENCIA_EN.
- When defined, the block adds input `parada` (1 bit). While parada=1:
  - motor_sube=motor_baja=0.
  - timer and estado freeze.
  - puerta_abierta holds its value.
  - listo=0; no accept.
- On parada=0, the block resumes from the frozen state and timer; the motor output restores on the next edge.
- When undefined: no `parada` port, and the block behaves exactly as above.

Test Plan:
- Reset, then solicitud=4'b0100, valid=1 at edge k (T_VIAJE=8, T_PUERTA=4):
  - motor_sube=1 for cycles k..k+15; piso=1 at k+8, piso=2 at k+16.
  - puerta_abierta=1 until k+20; atendido=1 for one cycle after k+20.
- From piso=2, request 4'b0001 -> motor_baja; piso 2->1->0 at 8-cycle steps; then doors open for 4 cycles, then a single atendido pulse.
- Request for the current floor (piso=0, solicitud=4'b0001):
  - PUERTA entered directly, no motor activity.
  - atendido pulses 4 cycles after the accept edge.
- Multi-bit solicitud=4'b1010 from floor 0 -> destino=1; new request 4'b1000 held valid during the atendido cycle -> accepted on that edge, travel to floor 3 with no idle gap.
- Interlock and ignore checks:
  - solicitud=0 with valid=1 -> no state change, no atendido.
  - Requests presented while moving are ignored.
  - Assertion over the whole run: motor_sube&motor_baja=0 and puerta_abierta&(motor_sube|motor_baja)=0.
- Reset and emergency stop:
  - rst_n low mid-travel -> piso=0, all outputs 0, listo=1 immediately, no atendido.
  - With PARADA_EMERGENCIA_EN: parada=1 for 5 cycles mid-travel extends arrival by exactly 5 cycles, with motors 0 during the stop.

Source files
------------

// File: rtl/control_cabina.sv
// Cabin controller: serves the lowest floor of the queued request, moves floor by floor,
// holds the doors open, then acks with atendido. Optional emergency stop: PARADA_EMERGENCIA_EN.
module control_cabina #(
  parameter int unsigned T_VIAJE  = 8,
  parameter int unsigned T_PUERTA = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef PARADA_EMERGENCIA_EN
  input  logic       parada,
`endif
  input  logic [3:0] solicitud,
  input  logic       solicitud_valida,
  output logic       listo,
  output logic       atendido,
  output logic [1:0] piso,
  output logic       motor_sube,
  output logic       motor_baja,
  output logic       puerta_abierta
);
  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] SUBIENDO = 2'd1;
  localparam logic [1:0] BAJANDO  = 2'd2;
  localparam logic [1:0] PUERTA   = 2'd3;

  localparam logic [15:0] RECARGA_VIAJE  = 16'(T_VIAJE - 1);
  localparam logic [15:0] RECARGA_PUERTA = 16'(T_PUERTA - 1);

  logic [1:0]  r_estado;
  logic [1:0]  r_piso;
  logic [1:0]  r_destino;
  logic [15:0] r_timer;
  logic        r_sube;
  logic        r_baja;
  logic        r_puerta;
  logic        r_atendido;

  logic        w_parada;
  logic        w_acepta;
  logic [1:0]  w_dest;
  logic [1:0]  w_piso_sig;
  logic        w_tope;

`ifdef PARADA_EMERGENCIA_EN
  assign w_parada = parada;
`else
  assign w_parada = 1'b0;
`endif

  assign listo    = (r_estado == REPOSO) && !w_parada;
  assign w_acepta = listo && solicitud_valida && (solicitud != 4'd0);

  // Multi-bit words serve only the lowest requested floor.
  always_comb begin
    w_dest = 2'd0;
    if (solicitud[0])      w_dest = 2'd0;
    else if (solicitud[1]) w_dest = 2'd1;
    else if (solicitud[2]) w_dest = 2'd2;
    else if (solicitud[3]) w_dest = 2'd3;
  end

  assign w_piso_sig = (r_estado == SUBIENDO) ? r_piso + 2'd1 : r_piso - 2'd1;
  // Travelling past the end floors cannot happen; if it does, open the doors where we are.
  assign w_tope = ((r_estado == SUBIENDO) && (r_piso == 2'd3)) ||
                  ((r_estado == BAJANDO)  && (r_piso == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= REPOSO;
      r_piso     <= 2'd0;
      r_destino  <= 2'd0;
      r_timer    <= 16'd0;
      r_sube     <= 1'b0;
      r_baja     <= 1'b0;
      r_puerta   <= 1'b0;
      r_atendido <= 1'b0;
    end else begin
      r_atendido <= 1'b0;
      if (w_parada) begin
        // Frozen: state, timer and door hold; motors drop until release.
        r_sube <= 1'b0;
        r_baja <= 1'b0;
      end else begin
        case (r_estado)
          REPOSO: begin
            if (w_acepta) begin
              r_destino <= w_dest;
              if (w_dest > r_piso) begin
                r_estado <= SUBIENDO;
                r_timer  <= RECARGA_VIAJE;
                r_sube   <= 1'b1;
              end else if (w_dest < r_piso) begin
                r_estado <= BAJANDO;
                r_timer  <= RECARGA_VIAJE;
                r_baja   <= 1'b1;
              end else begin
                r_estado <= PUERTA;
                r_timer  <= RECARGA_PUERTA;
                r_puerta <= 1'b1;
              end
            end
          end
          SUBIENDO, BAJANDO: begin
            r_sube <= (r_estado == SUBIENDO);
            r_baja <= (r_estado == BAJANDO);
            if (r_timer != 16'd0) begin
              r_timer <= r_timer - 16'd1;
            end else if (w_tope || (w_piso_sig == r_destino)) begin
              if (!w_tope) r_piso <= w_piso_sig;
              r_estado <= PUERTA;
              r_timer  <= RECARGA_PUERTA;
              r_sube   <= 1'b0;
              r_baja   <= 1'b0;
              r_puerta <= 1'b1;
            end else begin
              r_piso  <= w_piso_sig;
              r_timer <= RECARGA_VIAJE;
            end
          end
          PUERTA: begin
            if (r_timer != 16'd0) begin
              r_timer <= r_timer - 16'd1;
            end else begin
              r_puerta   <= 1'b0;
              r_estado   <= REPOSO;
              r_atendido <= 1'b1;
            end
          end
          default: r_estado <= REPOSO;
        endcase
      end
    end
  end

  assign piso           = r_piso;
  assign motor_sube     = r_sube;
  assign motor_baja     = r_baja;
  assign puerta_abierta = r_puerta;
  assign atendido       = r_atendido;

endmodule

// File: tb/tb_control_cabina.sv
// Scoreboard bench for control_cabina: a floor/latency model predicts each atendido pulse.
module tb_control_cabina;
  localparam int unsigned TV = 8;
  localparam int unsigned TP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sol = 4'd0;
  logic       val = 1'b0;
  logic       par = 1'b0;
  logic       listo, atendido, motor_sube, motor_baja, puerta_abierta;
  logic [1:0] piso;

  typedef struct {
    logic [1:0]  dest;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          model_piso = 0;
  int unsigned free_cyc = 0;

  control_cabina #(.T_VIAJE(TV), .T_PUERTA(TP)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PARADA_EMERGENCIA_EN
    .parada(par),
`endif
    .solicitud(sol),
    .solicitud_valida(val),
    .listo(listo),
    .atendido(atendido),
    .piso(piso),
    .motor_sube(motor_sube),
    .motor_baja(motor_baja),
    .puerta_abierta(puerta_abierta)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] s);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (s[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: interlocks every cycle, and each atendido pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("interlock_dir", 32'(motor_sube & motor_baja), 0);
      chk("interlock_door", 32'(puerta_abierta & (motor_sube | motor_baja)), 0);
      if (atendido === 1'b1) begin
        if (q.size() == 0) chk("atendido_unexpected", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("atendido_cycle", cyc, e.cyc);
          chk("atendido_piso", 32'(piso), 32'(e.dest));
        end
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance from its own idea of idle time.
  task automatic step(input logic v, input logic [3:0] s, input logic p);
    logic [1:0]  dst;
    int          d;
    int unsigned k;
    @(negedge clk);
    chk("listo", 32'(listo), 32'((cyc >= free_cyc) && !par));
    if (cyc >= free_cyc && !par) chk("piso_idle", 32'(piso), 32'(model_piso));
    if (par) chk("motor_parada", 32'(motor_sube | motor_baja), 0);
    par = p;
    val = v;
    sol = s;
    if (p && cyc < free_cyc) begin
      free_cyc++;
      q[q.size()-1].cyc++;
    end
    if (cyc >= free_cyc && !p && v && s != 4'd0) begin
      dst = lowest(s);
      d = (int'(dst) > model_piso) ? int'(dst) - model_piso : model_piso - int'(dst);
      k = cyc + 1;
      free_cyc = k + d * TV + TP;
      q.push_back('{dst, free_cyc});
      model_piso = int'(dst);
    end
  endtask

  task automatic run_to_free();
    int guard;
    guard = 0;
    while (cyc + 1 < free_cyc && guard < 200) begin
      step(0, 4'd0, 0);
      guard++;
    end
    if (guard >= 200) chk("run_timeout", 1, 0);
  endtask

  task automatic drain();
    run_to_free();
    step(0, 4'd0, 0);
    step(0, 4'd0, 0);
    chk("pending", q.size(), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_piso", 32'(piso), 0);
    chk("rst_listo", 32'(listo), 1);
    chk("rst_outs", 32'({motor_sube, motor_baja, puerta_abierta, atendido}), 0);
    rst_n = 1'b1;

    step(1, 4'b0100, 0);
    step(0, 4'd0, 0);
    chk("up_motor", 32'({motor_sube, motor_baja}), 2);
    drain();

    step(1, 4'b0001, 0);
    step(0, 4'd0, 0);
    chk("down_motor", 32'({motor_sube, motor_baja}), 1);
    drain();

    step(1, 4'b0001, 0);
    step(0, 4'd0, 0);
    chk("same_floor", 32'({motor_sube, motor_baja, puerta_abierta}), 1);
    drain();

    // Multi-bit word, then a request held during the atendido cycle.
    step(1, 4'b1010, 0);
    run_to_free();
    step(1, 4'b1000, 0);
    step(1, 4'b0001, 0);
    step(1, 4'b0100, 0);
    run_to_free();
    step(1, 4'd0, 0);
    step(1, 4'd0, 0);
    drain();

    // Reset in the middle of travel: no ack, back to floor 0.
    step(1, 4'b0001, 0);
    repeat (10) step(0, 4'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_piso", 32'(piso), 0);
    chk("midrst_listo", 32'(listo), 1);
    chk("midrst_outs", 32'({motor_sube, motor_baja, puerta_abierta, atendido}), 0);
    q.delete();
    model_piso = 0;
    free_cyc = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(0, 4'd0, 0);
    step(0, 4'd0, 0);

`ifdef PARADA_EMERGENCIA_EN
    step(1, 4'b0100, 0);
    repeat (3) step(0, 4'd0, 0);
    repeat (5) step(0, 4'd0, 1);
    step(0, 4'd0, 0);
    drain();
`endif

    repeat (1500) step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
